// File: rtl/morse_receiver.sv
// Morse key receiver: times marks/gaps in units and decodes letters A-H to a 3-bit code.
// Latency: letter_valid/letter_err pulse one cycle after the tick that completes the letter gap.
// Backpressure: none; pulses are single-cycle and letter holds until the next valid decode.
// Optional feature macro: MORSE_RX_WORD_GAP_EN (word_end pulse after a long space).
module morse_receiver #(
  parameter int TICK_DIV   = 25000000,
  parameter int DASH_MIN   = 2,
  parameter int LETTER_GAP = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       mark_led,
  output logic       word_end
);

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

  state_t      state_q, state_d;
  logic        key_s1, key_s2, key_s3;
  logic        rise, fall, edge_any;
  logic [24:0] div_cnt;
  logic        tick;
  logic [2:0]  dur;
  logic        dur_run;
  logic [3:0]  pattern;
  logic [2:0]  count;
  logic        ovf;
  logic        sym_take, sym_bit, gap_done;
  logic        dec_hit;
  logic [2:0]  dec_code;
  logic        valid_d, err_d;

  // Two-flop synchronizer plus a delay flop for edge detection
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_s3 <= 1'b0;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  assign mark_led = key_s2;
  assign rise     = key_s2 & ~key_s3;
  assign fall     = ~key_s2 & key_s3;
  assign edge_any = rise | fall;
  assign tick     = (div_cnt == 25'(TICK_DIV - 1));

  // Unit divider, phase-aligned to every key edge
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)         div_cnt <= '0;
    else if (edge_any) div_cnt <= '0;
    else if (tick)     div_cnt <= '0;
    else               div_cnt <= div_cnt + 25'd1;
  end

`ifdef MORSE_RX_WORD_GAP_EN
  assign dur_run = 1'b1;
`else
  assign dur_run = (state_q != IDLE);
`endif

  // Duration in units since the last edge, saturating at 7
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                 dur <= '0;
    else if (edge_any)                         dur <= '0;
    else if (tick && dur_run && dur != 3'd7)   dur <= dur + 3'd1;
  end

  // A mark of zero units is a glitch; anything longer is a symbol
  assign sym_take = (state_q == MARK) && fall && (dur != 3'd0);
  assign sym_bit  = (dur >= 3'(DASH_MIN));
  assign gap_done = (state_q == GAP) && tick && (dur == 3'(LETTER_GAP - 1));

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise) state_d = MARK;
      MARK: begin
        if (fall) begin
          if (dur != 3'd0)        state_d = GAP;
          else if (count != 3'd0) state_d = GAP;   // glitch: back to pending space
          else                    state_d = IDLE;  // glitch: back to empty space
        end
      end
      GAP: begin
        if (gap_done) state_d = rise ? MARK : IDLE;
        else if (rise) state_d = MARK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Symbol collection: first symbol lands in pattern[3]; a fifth only flags overflow
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pattern <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (gap_done) begin
      pattern <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (sym_take) begin
      if (count == 3'd4) begin
        ovf <= 1'b1;
      end else begin
        pattern <= pattern | (4'(sym_bit) << (2'd3 - count[1:0]));
        count   <= count + 3'd1;
      end
    end
  end

  // Output logic: decode the collected pattern and form the emit pulses
  always_comb begin
    dec_hit  = 1'b0;
    dec_code = 3'd0;
    case (count)
      3'd1: if (!pattern[3])               begin dec_hit = 1'b1; dec_code = 3'd4; end
      3'd2: if (pattern[3:2] == 2'b01)     begin dec_hit = 1'b1; dec_code = 3'd0; end
      3'd3: begin
        if (pattern[3:1] == 3'b100)        begin dec_hit = 1'b1; dec_code = 3'd3; end
        else if (pattern[3:1] == 3'b110)   begin dec_hit = 1'b1; dec_code = 3'd6; end
      end
      3'd4: begin
        case (pattern)
          4'b1000: begin dec_hit = 1'b1; dec_code = 3'd1; end
          4'b1010: begin dec_hit = 1'b1; dec_code = 3'd2; end
          4'b0010: begin dec_hit = 1'b1; dec_code = 3'd5; end
          4'b0000: begin dec_hit = 1'b1; dec_code = 3'd7; end
          default: ;
        endcase
      end
      default: ;
    endcase
    valid_d = gap_done && dec_hit && !ovf;
    err_d   = gap_done && (!dec_hit || ovf);
  end

  // Registered letter outputs; letter only changes on a valid decode
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
    end else begin
      letter_valid <= valid_d;
      letter_err   <= err_d;
      if (valid_d) letter <= dec_code;
    end
  end

`ifdef MORSE_RX_WORD_GAP_EN
  logic word_armed, word_fire;
  assign word_fire = word_armed && (state_q == IDLE) && tick && (dur == 3'd6) && !rise;

  // Word gap: arm after a letter closes into space, fire once when the space reaches 7 units
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      word_armed <= 1'b0;
      word_end   <= 1'b0;
    end else begin
      word_end <= word_fire;
      if (rise || word_fire)      word_armed <= 1'b0;
      else if (gap_done)          word_armed <= 1'b1;
    end
  end
`else
  assign word_end = 1'b0;
`endif

endmodule

// File: tb/tb_morse_receiver.sv
// Scoreboard bench for morse_receiver with TICK_DIV=4.
// Stimulus pushes expected {err, letter}; a negedge monitor pops on every pulse.
// Reset values and word_end count are checked directly.
module tb_morse_receiver;

  localparam int TD = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       key_in   = 1'b0;
  logic [2:0] letter;
  logic       letter_valid, letter_err, mark_led, word_end;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  logic [3:0] exp_q[$];

  morse_receiver #(.TICK_DIV(TD), .DASH_MIN(2), .LETTER_GAP(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_in      (key_in),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_err  (letter_err),
    .mark_led    (mark_led),
    .word_end    (word_end)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Monitor: every emit pulse is matched against the oldest expectation
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (word_end) we_cnt++;
      if (letter_valid || letter_err) begin
        logic [3:0] got, exp;
        got = {letter_err, letter};
        checks++;
        if (letter_valid && letter_err) begin
          failures++;
          $display("FAIL both_pulses: valid=%0b err=%0b, required not both high", letter_valid, letter_err);
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: err=%0b letter=%03b, required no pulse", letter_err, letter);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL emit: err=%0b letter=%03b, required err=%0b letter=%03b",
                     got[3], got[2:0], exp[3], exp[2:0]);
          end
        end
      end
    end
  end

  task automatic mark(input int n);
    @(negedge CLOCK_50) key_in = 1'b1;
    repeat (n * TD + 2) @(negedge CLOCK_50);
    key_in = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n * TD + 2) @(negedge CLOCK_50);
  endtask

  task automatic letter_end();
    repeat (24) @(negedge CLOCK_50);
  endtask

  // Send n symbols from pat (bit 3 first, 1 = dash) and expect exp
  task automatic send(input logic [3:0] pat, input int n, input logic [3:0] exp);
    exp_q.push_back(exp);
    for (int i = 0; i < n; i++) begin
      mark(pat[3 - i] ? 3 : 1);
      if (i < n - 1) gap(1);
    end
    letter_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({letter, letter_valid, letter_err, mark_led, word_end} !== 7'b0) begin
      failures++;
      $display("FAIL %s: letter=%03b valid=%0b err=%0b led=%0b word_end=%0b, required all 0",
               tag, letter, letter_valid, letter_err, mark_led, word_end);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int we0;
    int bound;
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("reset_values");
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);

    send(4'b0100, 2, {1'b0, 3'b000});   // A .-
    send(4'b1010, 4, {1'b0, 3'b010});   // C -.-.
    send(4'b0000, 1, {1'b0, 3'b100});   // E .

    // Five dots: overflow error, letter holds E
    exp_q.push_back({1'b1, 3'b100});
    for (int i = 0; i < 5; i++) begin
      mark(1);
      if (i < 4) gap(1);
    end
    letter_end();

    // Glitch mark shorter than one unit: nothing emitted, letter still E
    @(negedge CLOCK_50) key_in = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    key_in = 1'b0;
    repeat (30) @(negedge CLOCK_50);
    checks++;
    if (letter !== 3'b100) begin
      failures++;
      $display("FAIL glitch_hold: letter=%03b, required 100", letter);
    end

    send(4'b1000, 4, {1'b0, 3'b001});   // B -...
    send(4'b1000, 3, {1'b0, 3'b011});   // D -..
    send(4'b0010, 4, {1'b0, 3'b101});   // F ..-.
    send(4'b1100, 3, {1'b0, 3'b110});   // G --.
    send(4'b0000, 4, {1'b0, 3'b111});   // H ....

    // Reset after two symbols of B discards them
    mark(3); gap(1); mark(1); gap(1);
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    check_reset_outputs("midletter_reset");
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    send(4'b0000, 1, {1'b0, 3'b100});   // E after reset

    // Long space after a letter: word_end only when the feature is built in
    we0 = we_cnt;
    exp_q.push_back({1'b0, 3'b100});
    mark(1);
    repeat (8 * TD + 12) @(negedge CLOCK_50);
    checks++;
`ifdef MORSE_RX_WORD_GAP_EN
    if (we_cnt - we0 != 1) begin
      failures++;
      $display("FAIL word_end_count: got %0d, required 1", we_cnt - we0);
    end
`else
    if (we_cnt - we0 != 0) begin
      failures++;
      $display("FAIL word_end_count: got %0d, required 0", we_cnt - we0);
    end
`endif

    // Every expected emit must have been seen
    bound = 0;
    while (exp_q.size() != 0 && bound < 200) begin
      @(negedge CLOCK_50);
      bound++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d emits missing, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
